// File: rtl/dft_scan_reg.sv
// dft_scan_reg: scan-testable register with a load/capture/unload controller.
// Define DFT_MISR_EN to add a serial signature register compacting the unloaded bits.
module dft_scan_reg #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(5'b00101)
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic             test_mode,
    input  logic             scan_start,
    input  logic             scan_in,
    output logic             scan_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] UNLOAD  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam int         CW      = $clog2(WIDTH);

    logic [2:0]       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             last, shifting;

    assign last     = cnt == CW'(WIDTH - 1);
    assign shifting = state == LOAD || state == UNLOAD;

    // Dropping test_mode overrides every state: return to IDLE and load functionally.
    always_comb begin
        state_nxt = !test_mode          ? IDLE :
                    state == IDLE       ? (scan_start ? LOAD : IDLE) :
                    state == LOAD       ? (last ? CAPTURE : LOAD) :
                    state == CAPTURE    ? UNLOAD :
                    state == UNLOAD     ? (last ? DONE : UNLOAD) : IDLE;
        sreg_nxt  = !test_mode          ? data_in :
                    shifting            ? {scan_in, sreg[WIDTH-1:1]} :
                    state == CAPTURE    ? data_in : sreg;
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= (shifting && state_nxt == state) ? cnt + CW'(1) : '0;
        end
    end

    assign data_out = sreg;
    assign scan_out = sreg[0];
    assign busy     = state != IDLE;
    assign done     = state == DONE;

`ifdef DFT_MISR_EN
    logic [WIDTH-1:0] sig;

    always_ff @(posedge refclk or posedge reset) begin
        if (reset)
            sig <= '0;
        else if (state == IDLE && state_nxt == LOAD)
            sig <= '0;
        else if (state == UNLOAD)
            sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ WIDTH'(scan_out);
    end

    assign signature = sig;
`else
    logic unused_poly;

    assign unused_poly = ^POLY;
    assign signature   = '0;
`endif
endmodule

// File: tb/tb_dft_scan_reg.sv
// tb_dft_scan_reg: randomized scoreboard bench for dft_scan_reg against a cycle-level model.
module tb_dft_scan_reg;
    localparam int          W    = 5;
    localparam logic [W-1:0] POLY = 5'b00101;
    localparam logic [W-1:0] TOP  = 5'b10000;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         busy;
        logic         done;
        logic [W-1:0] sig;
    } exp_t;

    logic         refclk = 1'b0;
    logic         reset = 1'b1;
    logic         test_mode = 1'b0;
    logic         scan_start = 1'b0;
    logic         scan_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out, signature;
    logic         scan_out, busy, done;
    int           checks = 0;
    int           errors = 0;
    exp_t         q[$];
    logic [W-1:0] m_reg = '0;
    logic [W-1:0] m_sig = '0;

    dft_scan_reg #(.WIDTH(W), .POLY(POLY)) dut (
        .refclk(refclk), .reset(reset), .data_in(data_in), .data_out(data_out),
        .test_mode(test_mode), .scan_start(scan_start), .scan_in(scan_in),
        .scan_out(scan_out), .busy(busy), .done(done), .signature(signature)
    );

    always #5 refclk = ~refclk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Signature as polynomial arithmetic: multiply by x modulo POLY, then add the new bit.
    function automatic logic [W-1:0] sisr(input logic [W-1:0] s, input logic b);
        return W'(s * 2) ^ (s >= TOP ? POLY : '0) ^ W'(b);
    endfunction

    function automatic logic [W-1:0] exp_sig();
`ifdef DFT_MISR_EN
        return m_sig;
`else
        return '0;
`endif
    endfunction

    task automatic cyc(input logic r, tm, ss, si, input logic [W-1:0] di, input logic eb, ed);
        exp_t e;
        @(negedge refclk);
        reset = r; test_mode = tm; scan_start = ss; scan_in = si; data_in = di;
        e.dout = m_reg; e.busy = eb; e.done = ed; e.sig = exp_sig();
        q.push_back(e);
    endtask

    task automatic func(input logic [W-1:0] d);
        m_reg = d;
        cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), d, 1'b0, 1'b0);
    endtask

    task automatic idle_hold();
        cyc(1'b0, 1'b1, 1'b0, 1'($urandom), W'($urandom), 1'b0, 1'b0);
    endtask

    // bits[0] is shifted in first; edges are numbered from the one sampling scan_start.
    task automatic scan_seq(input logic [W-1:0] bits, cap, input int abort_at, reset_at);
        logic [W-1:0] nd;
        logic         si;
        m_sig = '0;
        cyc(1'b0, 1'b1, 1'b1, 1'($urandom), W'($urandom), 1'b1, 1'b0);
        for (int e = 1; e <= 2 * W + 2; e++) begin
            nd = W'($urandom);
            if (e == reset_at) begin
                @(posedge refclk);
                #3 reset = 1'b1;
                #1;
                chk("reset_data_out", data_out, 0);
                chk("reset_busy", busy, 0);
                chk("reset_done", done, 0);
                chk("reset_signature", signature, 0);
                m_reg = '0; m_sig = '0;
                cyc(1'b1, 1'b1, 1'b1, 1'b1, nd, 1'b0, 1'b0);
                cyc(1'b0, 1'b1, 1'b0, 1'b0, W'($urandom), 1'b0, 1'b0);
                return;
            end
            if (e == abort_at) begin
                m_reg = nd;
                cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), nd, 1'b0, 1'b0);
                return;
            end
            if (e <= W) begin
                m_reg = (m_reg >> 1) | (bits[e-1] ? TOP : '0);
                cyc(1'b0, 1'b1, 1'($urandom), bits[e-1], nd, 1'b1, 1'b0);
            end else if (e == W + 1) begin
                m_reg = cap;
                cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom), cap, 1'b1, 1'b0);
            end else if (e <= 2 * W + 1) begin
                si = 1'($urandom);
                m_sig = sisr(m_sig, m_reg[0]);
                m_reg = (m_reg >> 1) | (si ? TOP : '0);
                cyc(1'b0, 1'b1, 1'($urandom), si, nd, 1'b1, e == 2 * W + 1);
            end else begin
                cyc(1'b0, 1'b1, 1'b1, 1'($urandom), nd, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge refclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("data_out", data_out, e.dout);
                chk("scan_out", scan_out, e.dout[0]);
                chk("busy", busy, e.busy);
                chk("done", done, e.done);
                chk("signature", signature, e.sig);
            end
        end
    end

    initial begin : driver
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b0);
        func(5'b00001);
        func(5'b00100);
        scan_seq(5'b01101, 5'b10110, 0, 0);
        idle_hold();
        scan_seq(W'($urandom), W'($urandom), 3, 0);
        repeat (3) func(W'($urandom));
        scan_seq(W'($urandom), 5'b10110, 0, W + 3);
        idle_hold();
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: repeat ($urandom_range(1, 3)) func(W'($urandom));
                1: idle_hold();
                2: scan_seq(W'($urandom), W'($urandom), 0, 0);
                3: begin
                    scan_seq(W'($urandom), W'($urandom), $urandom_range(1, W + 1), 0);
                    func(W'($urandom));
                end
                default: scan_seq(W'($urandom), W'($urandom), 0, $urandom_range(2, 2 * W + 1));
            endcase
        end
        repeat (3) @(posedge refclk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dft_scan_reg.md
DFT_SCAN_REG -- requirements
Module: dft_scan_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning the data and scan-chain length (legal range 2..32).
REQ-002 The block SHALL have parameter POLY, default 5'b00101, meaning the signature feedback taps (x^5+x^2+1 for WIDTH=5).
REQ-003 The block SHALL have port refclk  input  1  meaning the single clock; all flops rise-edge.
REQ-004 The block SHALL have port reset  input  1  meaning the asynchronous, active-high reset.
REQ-005 The block SHALL have port data_in  input  WIDTH  meaning functional and capture data.
REQ-006 The block SHALL have port data_out  output  WIDTH  meaning the register contents (reg).
REQ-007 The block SHALL have port test_mode  input  1  meaning: 1 = scan controller enabled, 0 = functional.
REQ-008 The block SHALL have port scan_start  input  1  meaning: start one load/capture/unload sequence.
REQ-009 The block SHALL have port scan_in  input  1  meaning the serial scan data.
REQ-010 The block SHALL have port scan_out  output  1  meaning serial scan data out, equal to reg[0] at all times.
REQ-011 The block SHALL have port busy  output  1  meaning high in any state except IDLE.
REQ-012 The block SHALL have port done  output  1  meaning a one-cycle pulse at sequence completion.
REQ-013 The block SHALL have port signature  output  WIDTH  meaning the compacted unload signature (see Configuration).

Function
REQ-014 When test_mode=0, the block SHALL load reg <= data_in every cycle (1-cycle latency), with the FSM held in IDLE.
REQ-015 The FSM SHALL have states IDLE, LOAD, CAPTURE, UNLOAD, DONE.
REQ-016 In IDLE with test_mode=1, the block SHALL hold reg, and SHALL move to LOAD when scan_start=1 is sampled.
REQ-017 In LOAD and UNLOAD, reg SHALL shift right: reg <= {scan_in, reg[WIDTH-1:1]}.
REQ-018 Each of LOAD and UNLOAD SHALL last exactly WIDTH cycles, counted by a shift counter cleared on state entry.
REQ-019 CAPTURE SHALL last one cycle, with reg <= data_in.
REQ-020 DONE SHALL last one cycle, asserting done=1, holding reg, and then returning to IDLE.
REQ-021 done SHALL be high exactly 2*WIDTH+2 cycles after the edge that sampled scan_start.
REQ-022 scan_start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-023 If test_mode falls in any non-IDLE state, the FSM SHALL go to IDLE on the next edge with no done pulse, and reg SHALL load data_in on that edge.
REQ-024 scan_start and test_mode rising in the same cycle SHALL start a sequence.

Reset
REQ-025 Asserting reset SHALL immediately clear reg, signature, the counter, busy and done to 0 and force IDLE, including mid-sequence.
REQ-026 After reset deasserts, the first edge SHALL behave per REQ-014/REQ-016.

Configuration
REQ-027 With DFT_MISR_EN defined, signature SHALL clear on entry to LOAD.
REQ-028 With DFT_MISR_EN defined, each UNLOAD cycle SHALL update sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ scan_out, with scan_out taken as the LSB term.
REQ-029 With DFT_MISR_EN defined, signature SHALL hold its value in all other states.
REQ-030 Without DFT_MISR_EN, signature SHALL be constant 0, no signature flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-031 Functional mode: test_mode=0, data_in 00001 then 00100 -> data_out 00001, then 00100, each one cycle after the data is applied.
REQ-032 Load: WIDTH=5, scan_start, scan_in 1,0,1,1,0 over the LOAD cycles -> reg=01101 entering CAPTURE.
REQ-033 Capture/unload: data_in=10110 at CAPTURE -> scan_out 0,1,1,0,1 over the UNLOAD cycles; done exactly 12 cycles after the scan_start edge; busy=0 the cycle after.
REQ-034 Abort: test_mode dropped in the 3rd LOAD cycle -> IDLE next edge, no done, data_out follows data_in.
REQ-035 Reset in UNLOAD cycle 2 -> data_out=00000, busy=0, signature=0 immediately; scan_start pulsed during busy has no effect.
REQ-036 DFT_MISR_EN build: unloading 10110 -> signature equals the reference-model SISR value; non-MISR build -> signature=00000.
